vga_video_gen: RTL and testbench
================================

// Module: vga_video_gen
// PURPOSE
//  Upstream source for the VGA monitor model (vdbVGAMonitor) and the VGA_* pins.
//  - Generates VGA line/frame timing from pixel_clk.
//  - Produces registered hsync/vsync/de and a selectable built-in test pattern on r/g/b.
//  - Sits in the de10lite design between the pixel clock and the VGA output pins.
// PARAMETERS
//  H_ACTIVE  640  visible pixels per line
//  H_FP      16   horizontal front porch, in pixels
//  H_SYNC    96   hsync pulse width, in pixels
//  H_BP      48   horizontal back porch, in pixels
//  V_ACTIVE  480  visible lines per frame
//  V_FP      10   vertical front porch, in lines
//  V_SYNC    2    vsync pulse width, in lines
//  V_BP      33   vertical back porch, in lines
//  HS_POL    0    hsync active level (0 = active-low)
//  VS_POL    0    vsync active level (0 = active-low)
//  CW        4    colour channel width, in bits
// PORTS
//  pixel_clk    in   1              pixel clock; all logic is on its rising edge
//  rst          in   1              asynchronous, active-high reset
//  en           in   1              run enable; low = hold counters at origin, outputs blanked
//  pattern      in   2              test pattern select; sampled only at frame start
//  hsync        out  1              horizontal sync, polarity set by HS_POL
//  vsync        out  1              vertical sync, polarity set by VS_POL
//  de           out  1              active-video flag
//  r,g,b        out  CW each        pixel colour; all zero whenever de=0
//  x            out  $clog2(H_TOT)  current h counter value (aligned with outputs)
//  y            out  $clog2(V_TOT)  current v counter value (aligned with outputs)
//  frame_start  out  1              1-cycle pulse on the output cycle of h=0,v=0
// BEHAVIOUR
//  - Totals: H_TOT = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOT = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
//  - Reset values: hsync=~HS_POL, vsync=~VS_POL, de=0, r=g=b=0, x=y=0, frame_start=0.
//    Reset also clears both counters and the pattern latch (to 0).
//  - Counters (count only while en=1):
//    - h counts 0..H_TOT-1 and wraps to 0.
//    - v increments when h wraps, counts 0..V_TOT-1, and wraps to 0 when h and v both wrap.
//  - Decode, from the counter values:
//    - de = (h<H_ACTIVE) && (v<V_ACTIVE).
//    - hsync is active for H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC, on every line.
//    - vsync is active for V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC, for whole lines.
//  - Latency: every output is registered exactly 1 cycle after the counter state it describes.
//    hsync, vsync, de, rgb, x, y and frame_start are mutually aligned; there is no internal skew.
//  - Pattern latch:
//    - pattern is captured when the counters are at h=0,v=0.
//    - Changes during a frame have no effect until the next frame start.
//  - Patterns (the active value applies only while de=1):
//    - 0 colour bars: 8 bars, each H_ACTIVE/8 pixels wide; idx = h/(H_ACTIVE/8); c = 7-idx.
//      r={CW{c[2]}}, g={CW{c[1]}}, b={CW{c[0]}}; bars run white, yellow, magenta, red,
//      cyan, green, blue, black.
//    - 1 checkerboard: 32-pixel squares; white if h[5]^v[5]=0, else black.
//    - 2 grey ramp: r=g=b=h[CW+5:6].
//    - 3 solid white: all channels = {CW{1'b1}}.
//  - en deasserted:
//    - On the next edge the counters return to h=v=0 and hold.
//    - From the following output cycle: de=0, rgb=0, syncs inactive, frame_start=0.
//  - en reasserted:
//    - Counting restarts from h=0,v=0 and the pattern is re-latched.
//    - frame_start pulses 1 cycle after the first enabled edge.
//  - rst asserted mid-frame: all state and outputs go to reset values immediately (async).
//    Release resumes from the origin.
//  - No flow control: the sink samples every cycle.
// TESTING
//  - Frame period: rst release, en=1 -> frame_start pulses exactly 420000 cycles apart;
//    exactly 307200 de=1 cycles per frame.
//  - Line timing:
//    - de high for 640 cycles per line.
//    - hsync goes low exactly 656 cycles after de rises, for 96 cycles; 800 cycles per line.
//  - Frame timing: vsync goes low at the start of line 490 for 1600 cycles.
//    hsync keeps toggling during vsync.
//  - pattern=0: x=0 -> rgb F,F,F; x=80 -> F,F,0; x=320 -> 0,F,F; x=639 -> 0,0,0;
//    blanking -> 0,0,0.
//  - pattern switched 0->1 at line 100 -> bars continue to end of frame.
//    Next frame: x=0,y=0 white; x=32,y=0 black; x=32,y=32 white.
//  - en dropped mid-line, or rst pulsed mid-frame -> outputs blank/inactive and x=y=0.
//    On re-enable/release, frame_start pulses and the next frame period is exactly 420000 cycles.

Source files
------------

// File: rtl/vga_video_if.sv
// Video bus between the VGA timing/pattern generator and its sink:
// run controls flow into the generator, timing and colour flow out.
interface vga_video_if #(
    parameter int CW = 4,
    parameter int XW = 10,
    parameter int YW = 10
);
    logic          en;
    logic [1:0]    pattern;
    logic          hsync;
    logic          vsync;
    logic          de;
    logic [CW-1:0] r;
    logic [CW-1:0] g;
    logic [CW-1:0] b;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic          frame_start;

    modport master (
        input  en, pattern,
        output hsync, vsync, de, r, g, b, x, y, frame_start
    );

    modport slave (
        output en, pattern,
        input  hsync, vsync, de, r, g, b, x, y, frame_start
    );
endinterface

// File: rtl/vga_video_gen.sv
// VGA line/frame timing generator with registered syncs, data-enable and a
// frame-latched built-in test pattern, all outputs aligned one cycle behind the counters.
module vga_video_gen #(
    parameter int   H_ACTIVE = 640,
    parameter int   H_FP     = 16,
    parameter int   H_SYNC   = 96,
    parameter int   H_BP     = 48,
    parameter int   V_ACTIVE = 480,
    parameter int   V_FP     = 10,
    parameter int   V_SYNC   = 2,
    parameter int   V_BP     = 33,
    parameter logic HS_POL   = 1'b0,
    parameter logic VS_POL   = 1'b0,
    parameter int   CW       = 4
) (
    input  logic         pixel_clk,
    input  logic         rst,
    vga_video_if.master  vid
);
    localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int XW    = $clog2(H_TOT);
    localparam int YW    = $clog2(V_TOT);
    localparam int BAR_W = H_ACTIVE / 8;

    logic [XW-1:0] h_r;
    logic [YW-1:0] v_r;
    logic [1:0]    pat_r;

    logic          origin_s;
    logic          h_wrap_s;
    logic          v_wrap_s;
    logic [1:0]    pat_s;
    logic          de_s;
    logic          hs_act_s;
    logic          vs_act_s;
    logic [2:0]    bar_idx_s;
    logic [2:0]    bar_c_s;
    logic [CW-1:0] grey_s;
    logic [CW-1:0] r_s;
    logic [CW-1:0] g_s;
    logic [CW-1:0] b_s;

    assign origin_s  = (h_r == {XW{1'b0}}) && (v_r == {YW{1'b0}});
    assign h_wrap_s  = (h_r == XW'(H_TOT - 1));
    assign v_wrap_s  = (v_r == YW'(V_TOT - 1));
    // The first pixel of a frame must already use the pattern being latched on that edge.
    assign pat_s     = origin_s ? vid.pattern : pat_r;
    assign de_s      = (h_r < XW'(H_ACTIVE)) && (v_r < YW'(V_ACTIVE));
    assign hs_act_s  = (h_r >= XW'(H_ACTIVE + H_FP)) && (h_r < XW'(H_ACTIVE + H_FP + H_SYNC));
    assign vs_act_s  = (v_r >= YW'(V_ACTIVE + V_FP)) && (v_r < YW'(V_ACTIVE + V_FP + V_SYNC));
    assign bar_idx_s = 3'(h_r / XW'(BAR_W));
    assign bar_c_s   = 3'd7 - bar_idx_s;
    assign grey_s    = CW'(h_r >> 6);

    // Active-video colour for the current counter position and selected pattern.
    always_comb begin
        r_s = {CW{1'b0}};
        g_s = {CW{1'b0}};
        b_s = {CW{1'b0}};
        case (pat_s)
            2'd0: begin
                r_s = {CW{bar_c_s[2]}};
                g_s = {CW{bar_c_s[1]}};
                b_s = {CW{bar_c_s[0]}};
            end
            2'd1: begin
                if ((h_r[5] ^ v_r[5]) == 1'b0) begin
                    r_s = {CW{1'b1}};
                    g_s = {CW{1'b1}};
                    b_s = {CW{1'b1}};
                end else begin
                    r_s = {CW{1'b0}};
                    g_s = {CW{1'b0}};
                    b_s = {CW{1'b0}};
                end
            end
            2'd2: begin
                r_s = grey_s;
                g_s = grey_s;
                b_s = grey_s;
            end
            2'd3: begin
                r_s = {CW{1'b1}};
                g_s = {CW{1'b1}};
                b_s = {CW{1'b1}};
            end
            default: begin
                r_s = {CW{1'b0}};
                g_s = {CW{1'b0}};
                b_s = {CW{1'b0}};
            end
        endcase
    end

    // Pixel/line counters and the per-frame pattern latch.
    always_ff @(posedge pixel_clk or posedge rst) begin
        if (rst) begin
            h_r   <= {XW{1'b0}};
            v_r   <= {YW{1'b0}};
            pat_r <= 2'd0;
        end else if (!vid.en) begin
            h_r   <= {XW{1'b0}};
            v_r   <= {YW{1'b0}};
            pat_r <= pat_r;
        end else begin
            if (origin_s) begin
                pat_r <= vid.pattern;
            end else begin
                pat_r <= pat_r;
            end
            if (h_wrap_s) begin
                h_r <= {XW{1'b0}};
                v_r <= v_wrap_s ? {YW{1'b0}} : v_r + YW'(1);
            end else begin
                h_r <= h_r + XW'(1);
                v_r <= v_r;
            end
        end
    end

    // Registered outputs describing the counter state of the previous cycle.
    always_ff @(posedge pixel_clk or posedge rst) begin
        if (rst) begin
            vid.hsync       <= ~HS_POL;
            vid.vsync       <= ~VS_POL;
            vid.de          <= 1'b0;
            vid.r           <= {CW{1'b0}};
            vid.g           <= {CW{1'b0}};
            vid.b           <= {CW{1'b0}};
            vid.x           <= {XW{1'b0}};
            vid.y           <= {YW{1'b0}};
            vid.frame_start <= 1'b0;
        end else if (vid.en) begin
            vid.hsync       <= hs_act_s ? HS_POL : ~HS_POL;
            vid.vsync       <= vs_act_s ? VS_POL : ~VS_POL;
            vid.de          <= de_s;
            vid.r           <= de_s ? r_s : {CW{1'b0}};
            vid.g           <= de_s ? g_s : {CW{1'b0}};
            vid.b           <= de_s ? b_s : {CW{1'b0}};
            vid.x           <= h_r;
            vid.y           <= v_r;
            vid.frame_start <= origin_s;
        end else begin
            vid.hsync       <= ~HS_POL;
            vid.vsync       <= ~VS_POL;
            vid.de          <= 1'b0;
            vid.r           <= {CW{1'b0}};
            vid.g           <= {CW{1'b0}};
            vid.b           <= {CW{1'b0}};
            vid.x           <= {XW{1'b0}};
            vid.y           <= {YW{1'b0}};
            vid.frame_start <= 1'b0;
        end
    end
endmodule

// File: tb/tb_vga_video_gen.sv
// Scoreboard bench for vga_video_gen on a reduced 160x60 raster (128x48 visible):
// expected samples and frame_start pulses are queued by the stimulus and checked by a monitor.
module tb_vga_video_gen;
    localparam int H_TOT = 160;
    localparam int FRAME = 160 * 60;
    localparam int DE_PER_FRAME = 128 * 48;

    typedef struct {
        int          cyc;
        string       name;
        logic [29:0] val;
    } px_t;

    typedef struct {
        int cyc;
        int de_cnt;
    } fs_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_fail = 0;
    int   de_cnt = 0;

    px_t  px_q[$];
    fs_t  fs_q[$];

    vga_video_if #(.CW(4), .XW(8), .YW(6)) vid ();

    vga_video_gen #(
        .H_ACTIVE(128), .H_FP(8), .H_SYNC(16), .H_BP(8),
        .V_ACTIVE(48),  .V_FP(4), .V_SYNC(2),  .V_BP(6),
        .HS_POL(1'b0),  .VS_POL(1'b0), .CW(4)
    ) dut (
        .pixel_clk(clk),
        .rst(rst),
        .vid(vid)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic px(input string nm, input int c, input logic hs, input logic vs,
                      input logic de, input logic [11:0] rgb, input int xx, input int yy,
                      input logic fs);
        px_t e;
        e.cyc  = c;
        e.name = nm;
        e.val  = {hs, vs, de, rgb, 8'(xx), 6'(yy), fs};
        px_q.push_back(e);
    endtask

    task automatic fsx(input int c, input int d);
        fs_t e;
        e.cyc    = c;
        e.de_cnt = d;
        fs_q.push_back(e);
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    // Monitor: samples every falling edge, pops due entries and frame_start expectations.
    always @(negedge clk) begin
        px_t         e;
        fs_t         f;
        logic [29:0] act;
        act = {vid.hsync, vid.vsync, vid.de, vid.r, vid.g, vid.b, vid.x, vid.y, vid.frame_start};
        while (px_q.size() > 0 && px_q[0].cyc <= cyc) begin
            e = px_q.pop_front();
            n_cmp++;
            if (e.cyc != cyc) begin
                n_fail++;
                $display("FAIL %s: sample for cycle %0d missed (now %0d)", e.name, e.cyc, cyc);
            end else if (act !== e.val) begin
                n_fail++;
                $display("FAIL %s @%0d: got {hs,vs,de,rgb,x,y,fs}=%h expected %h",
                         e.name, cyc, act, e.val);
            end
        end
        if (vid.frame_start === 1'b1) begin
            n_cmp++;
            if (fs_q.size() == 0) begin
                n_fail++;
                $display("FAIL frame_start: unexpected pulse at cycle %0d", cyc);
            end else begin
                f = fs_q.pop_front();
                if (f.cyc != cyc) begin
                    n_fail++;
                    $display("FAIL frame_start: pulse at cycle %0d expected %0d", cyc, f.cyc);
                end
                if (f.de_cnt >= 0) begin
                    n_cmp++;
                    if (de_cnt != f.de_cnt) begin
                        n_fail++;
                        $display("FAIL de_count: %0d de cycles in frame, expected %0d",
                                 de_cnt, f.de_cnt);
                    end
                end
            end
            de_cnt = (vid.de === 1'b1) ? 1 : 0;
        end else begin
            de_cnt = de_cnt + ((vid.de === 1'b1) ? 1 : 0);
        end
    end

    initial begin
        int b0, b1, b2, b3, b4, b5, b6, n, m, r;
        rst         = 1'b1;
        vid.en      = 1'b1;
        vid.pattern = 2'd0;
        px("reset", 2, 1'b1, 1'b1, 1'b0, 12'h000, 0, 0, 1'b0);

        @(negedge clk);
        wait_cyc(4);
        rst = 1'b0;
        b0 = cyc + 1;
        b1 = b0 + FRAME;
        b2 = b1 + FRAME;
        b3 = b2 + FRAME;
        n  = b3 + 30 * H_TOT + 50;
        m  = n + 20;
        b4 = m + 1;
        b5 = b4 + FRAME;
        r  = b5 + 6 * H_TOT + 40;
        b6 = r + 6;

        // Frame 0: colour bars, line and frame timing.
        px("bar_white", b0,       1'b1, 1'b1, 1'b1, 12'hFFF, 0,   0, 1'b1);
        px("bar_yellow", b0 + 16, 1'b1, 1'b1, 1'b1, 12'hFF0, 16,  0, 1'b0);
        px("bar_cyan",  b0 + 64,  1'b1, 1'b1, 1'b1, 12'h0FF, 64,  0, 1'b0);
        px("bar_black", b0 + 127, 1'b1, 1'b1, 1'b1, 12'h000, 127, 0, 1'b0);
        px("de_end",    b0 + 128, 1'b1, 1'b1, 1'b0, 12'h000, 128, 0, 1'b0);
        px("hs_pre",    b0 + 135, 1'b1, 1'b1, 1'b0, 12'h000, 135, 0, 1'b0);
        px("hs_on",     b0 + 136, 1'b0, 1'b1, 1'b0, 12'h000, 136, 0, 1'b0);
        px("hs_last",   b0 + 151, 1'b0, 1'b1, 1'b0, 12'h000, 151, 0, 1'b0);
        px("hs_off",    b0 + 152, 1'b1, 1'b1, 1'b0, 12'h000, 152, 0, 1'b0);
        px("line_end",  b0 + 159, 1'b1, 1'b1, 1'b0, 12'h000, 159, 0, 1'b0);
        px("line1",     b0 + 160, 1'b1, 1'b1, 1'b1, 12'hFFF, 0,   1, 1'b0);
        px("bar_keep",  b0 + 20 * H_TOT + 32,  1'b1, 1'b1, 1'b1, 12'hF0F, 32,  20, 1'b0);
        px("act_last",  b0 + 47 * H_TOT,       1'b1, 1'b1, 1'b1, 12'hFFF, 0,   47, 1'b0);
        px("vblank",    b0 + 48 * H_TOT,       1'b1, 1'b1, 1'b0, 12'h000, 0,   48, 1'b0);
        px("vs_pre",    b0 + 51 * H_TOT + 159, 1'b1, 1'b1, 1'b0, 12'h000, 159, 51, 1'b0);
        px("vs_on",     b0 + 52 * H_TOT,       1'b1, 1'b0, 1'b0, 12'h000, 0,   52, 1'b0);
        px("vs_hs",     b0 + 53 * H_TOT + 140, 1'b0, 1'b0, 1'b0, 12'h000, 140, 53, 1'b0);
        px("vs_off",    b0 + 54 * H_TOT,       1'b1, 1'b1, 1'b0, 12'h000, 0,   54, 1'b0);
        // Frame 1: checkerboard latched from the mid-frame change.
        px("ck_org",    b1,                    1'b1, 1'b1, 1'b1, 12'hFFF, 0,  0,  1'b1);
        px("ck_32_0",   b1 + 32,               1'b1, 1'b1, 1'b1, 12'h000, 32, 0,  1'b0);
        px("ck_31_32",  b1 + 32 * H_TOT + 31,  1'b1, 1'b1, 1'b1, 12'h000, 31, 32, 1'b0);
        px("ck_32_32",  b1 + 32 * H_TOT + 32,  1'b1, 1'b1, 1'b1, 12'hFFF, 32, 32, 1'b0);
        // Frame 2: grey ramp; frame 3: solid white.
        px("grey_0",    b2,                    1'b1, 1'b1, 1'b1, 12'h000, 0,   0, 1'b1);
        px("grey_64",   b2 + 64,               1'b1, 1'b1, 1'b1, 12'h111, 64,  0, 1'b0);
        px("grey_127",  b2 + 5 * H_TOT + 127,  1'b1, 1'b1, 1'b1, 12'h111, 127, 5, 1'b0);
        px("white_org", b3,                    1'b1, 1'b1, 1'b1, 12'hFFF, 0,   0,  1'b1);
        px("white_mid", b3 + 20 * H_TOT + 100, 1'b1, 1'b1, 1'b1, 12'hFFF, 100, 20, 1'b0);
        px("white_blk", b3 + 20 * H_TOT + 130, 1'b1, 1'b1, 1'b0, 12'h000, 130, 20, 1'b0);
        // en dropped mid-line, then re-enabled with a new pattern.
        px("en_last",   n,      1'b1, 1'b1, 1'b1, 12'hFFF, 50, 30, 1'b0);
        px("en_blank",  n + 1,  1'b1, 1'b1, 1'b0, 12'h000, 0,  0,  1'b0);
        px("en_hold",   m,      1'b1, 1'b1, 1'b0, 12'h000, 0,  0,  1'b0);
        px("reen_org",  b4,     1'b1, 1'b1, 1'b1, 12'hFFF, 0,  0,  1'b1);
        px("reen_32",   b4 + 32, 1'b1, 1'b1, 1'b1, 12'h000, 32, 0, 1'b0);
        // Asynchronous reset mid-frame.
        px("pre_rst",   r - 1,  1'b1, 1'b1, 1'b1, 12'h000, 39, 6, 1'b0);
        px("rst_async", r,      1'b1, 1'b1, 1'b0, 12'h000, 0,  0, 1'b0);
        px("rst_hold",  r + 3,  1'b1, 1'b1, 1'b0, 12'h000, 0,  0, 1'b0);
        px("rel_org",   b6,     1'b1, 1'b1, 1'b1, 12'hFFF, 0,  0, 1'b1);
        px("rel_16",    b6 + 16, 1'b1, 1'b1, 1'b1, 12'hFF0, 16, 0, 1'b0);

        fsx(b0, -1);
        fsx(b1, DE_PER_FRAME);
        fsx(b2, DE_PER_FRAME);
        fsx(b3, DE_PER_FRAME);
        fsx(b4, -1);
        fsx(b5, DE_PER_FRAME);
        fsx(b6, -1);
        fsx(b6 + FRAME, DE_PER_FRAME);

        wait_cyc(b0 + 10 * H_TOT + 5);
        vid.pattern = 2'd1;
        wait_cyc(b1 + 10 * H_TOT + 5);
        vid.pattern = 2'd2;
        wait_cyc(b2 + 10 * H_TOT + 5);
        vid.pattern = 2'd3;
        wait_cyc(n);
        vid.en      = 1'b0;
        vid.pattern = 2'd1;
        wait_cyc(m);
        vid.en = 1'b1;
        wait_cyc(r - 1);
        @(posedge clk);
        #2;
        rst         = 1'b1;
        vid.pattern = 2'd0;
        wait_cyc(r + 5);
        rst = 1'b0;
        wait_cyc(b6 + FRAME + 20);

        while (px_q.size() > 0) begin
            px_t e;
            e = px_q.pop_front();
            n_cmp++;
            n_fail++;
            $display("FAIL %s: sample for cycle %0d never checked", e.name, e.cyc);
        end
        while (fs_q.size() > 0) begin
            fs_t f;
            f = fs_q.pop_front();
            n_cmp++;
            n_fail++;
            $display("FAIL frame_start: expected pulse at cycle %0d never seen", f.cyc);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
